// File: rtl/epl_column_read_sub_pkg.sv
// Shared constants, state encoding and select helpers for the EPLFFRAM02 column read path.
package epl_column_read_sub_pkg;

  localparam int unsigned COLUMN      = 14;
  localparam int unsigned TWORD_WIDTH = 7;
  localparam int unsigned ADDR_AYO    = 2;

  localparam logic [COLUMN-1:0] MASK_EVEN = 14'h1555;
  localparam logic [COLUMN-1:0] MASK_ODD  = 14'h2AAA;

  localparam logic [ADDR_AYO-1:0] SEL_EVEN = 2'b01;
  localparam logic [ADDR_AYO-1:0] SEL_ODD  = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSense = 2'd1,
    StValid = 2'd2
  } crd_state_e;

  // Only the two one-hot codes are legal column-group selects.
  function automatic logic sel_legal(input logic [ADDR_AYO-1:0] sel);
    return (sel == SEL_EVEN) || (sel == SEL_ODD);
  endfunction

  // Read-enable mask for a select; illegal selects enable nothing.
  function automatic logic [COLUMN-1:0] sel_mask(input logic [ADDR_AYO-1:0] sel);
    logic [COLUMN-1:0] mask;
    mask = '0;
    if (sel == SEL_EVEN) mask = MASK_EVEN;
    if (sel == SEL_ODD)  mask = MASK_ODD;
    return mask;
  endfunction

endpackage

// File: rtl/epl_column_gather.sv
// Combinational gather of interleaved sense-amp bits into a codeword.
// Inverse of the write-side scatter: bit k comes from column 2k (even) or 2k+1 (odd).
module epl_column_gather
  import epl_column_read_sub_pkg::*;
(
  input  logic [ADDR_AYO-1:0]    sel_i,
  input  logic [COLUMN-1:0]      data_i,
  output logic [TWORD_WIDTH-1:0] codeword_o
);

  // Pick the even or odd column of each pair; anything but the odd code reads even.
  always_comb begin
    codeword_o = '0;
    for (int k = 0; k < TWORD_WIDTH; k++) begin
      codeword_o[k] = (sel_i == SEL_ODD) ? data_i[2*k+1] : data_i[2*k];
    end
  end

endmodule

// File: rtl/epl_column_read_sub.sv
// Column read sequencer for the EPLFFRAM02 wrapper: drives per-column read enables for a
// fixed sense latency, gathers the selected columns into a codeword and hands it downstream
// over a valid/ready handshake.
// Optional build macro EPL_COLRD_DBLSAMPLE_EN: sense one extra cycle and flag pErr_o when the
// last two samples of the selected columns disagree.
module epl_column_read_sub
  import epl_column_read_sub_pkg::*;
#(
  parameter int unsigned SENSE_LAT = 2
) (
  input  logic                   pClk_i,
  input  logic                   pRst_i,
  input  logic [ADDR_AYO-1:0]    pAcy_i,
  input  logic                   pRdReq_i,
  output logic                   pBusy_o,
  output logic [COLUMN-1:0]      pRe_o,
  input  logic [COLUMN-1:0]      pDo_i,
  output logic [TWORD_WIDTH-1:0] pCodeword_o,
  output logic                   pValid_o,
  input  logic                   pReady_i,
  output logic                   pErr_o
);

  localparam int unsigned CntW = 4;

`ifdef EPL_COLRD_DBLSAMPLE_EN
  // One extra sense cycle so the last two edges can both be sampled.
  localparam logic [CntW-1:0] CntLoad = CntW'(SENSE_LAT);
`else
  localparam logic [CntW-1:0] CntLoad = CntW'(SENSE_LAT - 1);
`endif

  crd_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [ADDR_AYO-1:0]    sel_q, sel_d;
  logic [COLUMN-1:0]      re_q, re_d;
  logic [TWORD_WIDTH-1:0] cw_q, cw_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [TWORD_WIDTH-1:0] gather_cw;
  logic                   req_legal;
`ifdef EPL_COLRD_DBLSAMPLE_EN
  logic [TWORD_WIDTH-1:0] first_q, first_d;
`endif

  assign req_legal = sel_legal(pAcy_i);

  epl_column_gather u_gather (
    .sel_i      (sel_q),
    .data_i     (pDo_i),
    .codeword_o (gather_cw)
  );

  // State register.
  always_ff @(posedge pClk_i) begin
    if (pRst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (pRdReq_i) state_d = req_legal ? StSense : StValid;
      end
      StSense: begin
        if (cnt_q == '0) state_d = StValid;
      end
      StValid: begin
        if (pReady_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, counter and latched select.
  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    re_d    = re_q;
    cw_d    = cw_q;
    valid_d = valid_q;
    err_d   = err_q;
`ifdef EPL_COLRD_DBLSAMPLE_EN
    first_d = first_q;
`endif
    case (state_q)
      StIdle: begin
        if (pRdReq_i) begin
          sel_d = pAcy_i;
          if (req_legal) begin
            cnt_d = CntLoad;
            re_d  = sel_mask(pAcy_i);
          end else begin
            // Bad select skips the array entirely and reports straight away.
            cw_d    = '0;
            err_d   = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      StSense: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
`ifdef EPL_COLRD_DBLSAMPLE_EN
          if (cnt_q == CntW'(1)) first_d = gather_cw;
`endif
        end else begin
          re_d    = '0;
          valid_d = 1'b1;
          cw_d    = gather_cw;
`ifdef EPL_COLRD_DBLSAMPLE_EN
          err_d   = (first_q != gather_cw);
`else
          err_d   = 1'b0;
`endif
        end
      end
      StValid: begin
        // Codeword is left as-is after the handshake; only valid/err drop.
        if (pReady_i) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge pClk_i) begin
    if (pRst_i) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      re_q    <= '0;
      cw_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef EPL_COLRD_DBLSAMPLE_EN
      first_q <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      re_q    <= re_d;
      cw_q    <= cw_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef EPL_COLRD_DBLSAMPLE_EN
      first_q <= first_d;
`endif
    end
  end

  assign pBusy_o     = (state_q != StIdle);
  assign pRe_o       = re_q;
  assign pCodeword_o = cw_q;
  assign pValid_o    = valid_q;
  assign pErr_o      = err_q;

endmodule

// File: tb/tb_epl_column_read_sub.sv
// Scoreboard bench for epl_column_read_sub: the driver pushes the expected response of each
// read, a negedge monitor checks enables, latency and the delivered codeword.
module tb_epl_column_read_sub;

  localparam int SL = 2;

  logic        pClk_i = 1'b0;
  logic        pRst_i;
  logic [1:0]  pAcy_i;
  logic        pRdReq_i;
  logic        pBusy_o;
  logic [13:0] pRe_o;
  logic [13:0] pDo_i;
  logic [6:0]  pCodeword_o;
  logic        pValid_o;
  logic        pReady_i;
  logic        pErr_o;

  epl_column_read_sub #(.SENSE_LAT(SL)) dut (
    .pClk_i      (pClk_i),
    .pRst_i      (pRst_i),
    .pAcy_i      (pAcy_i),
    .pRdReq_i    (pRdReq_i),
    .pBusy_o     (pBusy_o),
    .pRe_o       (pRe_o),
    .pDo_i       (pDo_i),
    .pCodeword_o (pCodeword_o),
    .pValid_o    (pValid_o),
    .pReady_i    (pReady_i),
    .pErr_o      (pErr_o)
  );

  always #5 pClk_i = ~pClk_i;

  typedef struct {
    logic [13:0] mask;
    logic [6:0]  cw;
    logic        err;
    int          req_cyc;
    int          lat;
    int          recnt;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;

  always @(posedge pClk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: bit k of the codeword is column 2k for even, 2k+1 for odd.
  function automatic logic [6:0] model_gather(input bit odd, input logic [13:0] d);
    logic [6:0] cw;
    for (int k = 0; k < 7; k++) cw[k] = d[2*k + (odd ? 1 : 0)];
    return cw;
  endfunction

  function automatic logic [13:0] model_mask(input bit odd);
    logic [13:0] m;
    for (int i = 0; i < 14; i++) m[i] = ((i % 2) == (odd ? 1 : 0));
    return m;
  endfunction

  // One read: d1 is held through the nominal sample edge, d2 afterwards.
  task automatic do_read(input logic [1:0] sel, input logic [13:0] d1, input logic [13:0] d2,
                         input int rdy_dly, input bit hammer);
    item_t it;
    bit    legal;
    bit    odd;
    int    n;
    legal = (sel == 2'b01) || (sel == 2'b10);
    odd   = (sel == 2'b10);
    it.req_cyc = cyc;
    if (!legal) begin
      it.mask = '0; it.cw = '0; it.err = 1'b1; it.lat = 1; it.recnt = 0;
    end else begin
      it.mask = model_mask(odd);
`ifdef EPL_COLRD_DBLSAMPLE_EN
      it.cw    = model_gather(odd, d2);
      it.err   = (model_gather(odd, d1) != model_gather(odd, d2));
      it.lat   = SL + 2;
      it.recnt = SL + 1;
`else
      it.cw    = model_gather(odd, d1);
      it.err   = 1'b0;
      it.lat   = SL + 1;
      it.recnt = SL;
`endif
    end
    sb.push_back(it);
    pAcy_i = sel; pRdReq_i = 1'b1; pDo_i = d1;
    @(posedge pClk_i); #1;
    pRdReq_i = hammer;
    pAcy_i   = 2'($urandom);
    for (int i = 0; i < SL; i++) begin
      if (!pValid_o) pReady_i = 1'($urandom);
      @(posedge pClk_i); #1;
    end
    pDo_i = d2;
    n = 0;
    while (!pValid_o && n < 40) begin
      pReady_i = 1'b0;
      @(posedge pClk_i); #1;
      n++;
    end
    pReady_i = 1'b0;
    check("valid_timeout", {31'd0, pValid_o}, 32'd1);
    repeat (rdy_dly) begin
      @(posedge pClk_i); #1;
    end
    pReady_i = 1'b1; pRdReq_i = 1'b0;
    @(posedge pClk_i); #1;
    pReady_i = 1'b0;
    check("valid_drop", {31'd0, pValid_o}, 32'd0);
  endtask

  // Monitor: checks enables, latency, codeword and its stability against the scoreboard head.
  always @(negedge pClk_i) begin
    static int  re_cnt = 0;
    static bit  prev_valid = 1'b0;
    item_t h;
    if (pRst_i || !mon_en) begin
      re_cnt = 0;
      prev_valid = 1'b0;
    end else begin
      if (pRe_o != '0) begin
        re_cnt++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL re_unexpected actual=%0h required=0", pRe_o);
        end else begin
          h = sb[0];
          check("re_mask", {18'd0, pRe_o}, {18'd0, h.mask});
        end
      end
      if (pValid_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL valid_unexpected actual=1 required=0");
        end else begin
          h = sb[0];
          if (!prev_valid) begin
            check("latency", cyc - h.req_cyc, h.lat);
            check("re_cycles", re_cnt, h.recnt);
            re_cnt = 0;
          end
          check("codeword", {25'd0, pCodeword_o}, {25'd0, h.cw});
          check("err", {31'd0, pErr_o}, {31'd0, h.err});
          check("busy_in_valid", {31'd0, pBusy_o}, 32'd1);
          check("re_off_in_valid", {18'd0, pRe_o}, 32'd0);
          if (pReady_i) void'(sb.pop_front());
        end
      end
      prev_valid = pValid_o;
    end
  end

  task automatic check_idle(input string name);
    check({name, "_re"}, {18'd0, pRe_o}, 32'd0);
    check({name, "_cw"}, {25'd0, pCodeword_o}, 32'd0);
    check({name, "_valid"}, {31'd0, pValid_o}, 32'd0);
    check({name, "_err"}, {31'd0, pErr_o}, 32'd0);
    check({name, "_busy"}, {31'd0, pBusy_o}, 32'd0);
  endtask

  initial begin
    logic [1:0]  sel;
    logic [13:0] d1;
    logic [13:0] d2;
    int          r;
    pRst_i = 1'b1; pAcy_i = '0; pRdReq_i = 1'b0; pDo_i = '0; pReady_i = 1'b0;
    repeat (3) @(posedge pClk_i);
    #1;
    check_idle("reset");
    pRst_i = 1'b0;
    @(posedge pClk_i); #1;

    // Reset in the middle of SENSE discards the read.
    pAcy_i = 2'b01; pRdReq_i = 1'b1; pDo_i = 14'h3FFF;
    @(posedge pClk_i); #1;
    pRdReq_i = 1'b0;
    check("sense_busy", {31'd0, pBusy_o}, 32'd1);
    pRst_i = 1'b1;
    repeat (3) @(posedge pClk_i);
    #1;
    check_idle("mid_reset");
    pRst_i = 1'b0;
    @(posedge pClk_i); #1;
    check_idle("post_reset");
    mon_en = 1'b1;

    do_read(2'b01, 14'h1555, 14'h1555, 0, 1'b0);
    do_read(2'b10, 14'h2A00, 14'h2A00, 5, 1'b0);
    do_read(2'b11, 14'h3FFF, 14'h3FFF, 1, 1'b0);
    do_read(2'b00, 14'h1234, 14'h1234, 0, 1'b0);
    do_read(2'b01, 14'h0AAA, 14'h0AAA, 3, 1'b1);
    do_read(2'b10, 14'h1555, 14'h2AAA, 2, 1'b1);
    // Bit 0 changes between the last two sense edges.
    do_read(2'b01, 14'h1555, 14'h1554, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      sel = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      d1  = 14'($urandom);
      d2  = ($urandom_range(0, 1) == 1) ? d1 : (d1 ^ 14'($urandom));
      do_read(sel, d1, d2, $urandom_range(0, 4), 1'($urandom));
    end

    repeat (3) @(posedge pClk_i);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    check("final_busy", {31'd0, pBusy_o}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
